radix_4_ntt_pipe: RTL
=====================

# radix_4_ntt_pipe

Pipelined, parametrised radix-4 decimation-in-frequency NTT butterfly with a valid/ready stream interface, a per-beat forward/inverse mode, and a pass-through tag. It supersedes the combinational radix-4 butterfly as the compute core of the NTT datapath and sits between the coefficient memory read port and the write-back path. It accepts one butterfly per cycle, has a fixed 4-cycle latency, and applies full backpressure.

## Interface
- N, 17, coefficient width in bits; Q < 2^N
- Q, 65537, odd prime modulus
- W, 256, primitive 4th root of unity mod Q (W^2 ≡ Q-1)
- TAGW, 8, width of the user tag carried alongside each beat

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat this cycle
- in_inv  in  1  0 = forward (uses W), 1 = inverse (uses Q-W)
- in_tag  in  TAGW  user tag, returned unchanged with the result
- a0..a3  in  N each  input coefficients, each in [0,Q)
- tf0..tf3  in  N each  output twiddles, each in [0,Q)
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts the result this cycle
- out_tag  out  TAGW  tag of the result beat
- A0..A3  out  N each  results, each in [0,Q)

## Operation
- Per beat, with w = W (forward) or Q-W (inverse) and all arithmetic mod Q:
  - X0 = a0+a1+a2+a3
  - X1 = (a0-a2) + w·(a1-a3)
  - X2 = (a0+a2) - (a1+a3)
  - X3 = (a0-a2) - w·(a1-a3)
  - Ak = Xk·tfk for k = 0..3
- Every output is fully reduced into [0,Q). Subtractions add Q before reduction, so there is no negative wrap.
- Four pipeline stages, each holding a valid bit, tag, mode and data:
  - S1: register the inputs.
  - S2: compute s02 = a0+a2, d02 = a0-a2, s13 = a1+a3, and m = w·(a1-a3) mod Q. The product is 2N bits wide and is reduced in this stage.
  - S3: compute X0..X3 mod Q, then form the raw products Xk·tfk (2N bits each).
  - S4: reduce each product mod Q into the output registers.
- Mode is sampled per beat and travels with the beat. Mixed forward and inverse beats may be issued back to back.
- Global advance enable: en = !out_valid || out_ready.
  - in_ready = en.
  - When en = 0, all stages hold their contents.
- Bubbles (in_valid = 0 while en = 1) propagate as valid = 0 stages. Beat order is always preserved.
- Inputs outside [0,Q) produce unspecified A data. Valid, tag and ordering are still correct.

## Timing
- Reset (rst_n = 0 at a clock edge):
  - All stage valid bits clear, so out_valid = 0.
  - A0..A3 = 0 and out_tag = 0.
  - in_ready = 1 from the cycle after reset.
- Reset mid-stream discards all in-flight beats. No stale beat appears after rst_n returns high.
- Latency: a beat accepted at edge k (in_valid && in_ready) with no stall drives out_valid = 1 with its data in the cycle after edge k+3. That is 4 cycles of register latency.
- Throughput: 1 beat/cycle while out_ready = 1.
- Backpressure:
  - While out_valid && !out_ready, out_valid, A0..A3 and out_tag hold stable and in_ready = 0.
  - in_ready is combinational from out_valid and out_ready only. It never depends on in_valid.
- Simultaneous accept and drain in the same cycle is legal and loses no beat.
- With out_ready held high, in_ready is permanently 1.

## Test plan
- Impulse, forward, Q=65537: a=(1,0,0,0), tf=(1,1,1,1), in_tag=0x11 → A=(1,1,1,1), out_tag=0x11, out_valid 4 cycles after acceptance.
- Mode check: a=(0,1,0,0), tf=(1,1,1,1).
  - in_inv=0 → A=(1,256,65536,65281).
  - Next beat with in_inv=1 → A=(1,65281,65536,256).
  - The two beats are issued back to back.
- Arithmetic, forward: a=(1,2,3,4), tf=(1,2,3,4) → A=(10,64509,65531,2040).
- Boundary values: a=(65536,65536,65536,65536), tf all 65536, forward → A=(4,0,0,0).
- Backpressure: stream 6 beats with tags 0..5 and deassert out_ready for 3 cycles after the first result appears.
  - in_ready = 0 and outputs stay stable throughout the stall.
  - All 6 beats emerge in tag order with correct data; none dropped or duplicated.
- Reset mid-stream: issue 3 beats, then hold rst_n = 0 for 1 edge while 2 beats are in flight.
  - out_valid = 0 and A0..A3 = 0 on the following cycle.
  - No in-flight beat ever emerges.
  - A new beat issued after reset returns correctly 4 cycles later.

Source files
------------

// File: rtl/radix_4_ntt_pipe.sv
// Radix-4 DIF NTT butterfly, four register stages, valid/ready stream with a
// single global advance enable; forward/inverse mode and tag travel per beat.
module radix_4_ntt_pipe #(
  parameter int N    = 17,
  parameter int Q    = 65537,
  parameter int W    = 256,
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_inv,
  input  logic [TAGW-1:0] in_tag,
  input  logic [N-1:0]    a0,
  input  logic [N-1:0]    a1,
  input  logic [N-1:0]    a2,
  input  logic [N-1:0]    a3,
  input  logic [N-1:0]    tf0,
  input  logic [N-1:0]    tf1,
  input  logic [N-1:0]    tf2,
  input  logic [N-1:0]    tf3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TAGW-1:0] out_tag,
  output logic [N-1:0]    A0,
  output logic [N-1:0]    A1,
  output logic [N-1:0]    A2,
  output logic [N-1:0]    A3
);

  localparam logic [N-1:0]   QN = N'(Q);
  localparam logic [2*N-1:0] Q2 = (2*N)'(Q);
  localparam logic [N-1:0]   WF = N'(W);
  localparam logic [N-1:0]   WI = N'(Q - W);

  function automatic logic [N-1:0] add_mod(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, QN}) s = s - {1'b0, QN};
    return N'(s);
  endfunction

  // Adding Q before subtracting keeps the result non-negative.
  function automatic logic [N-1:0] sub_mod(input logic [N-1:0] x, input logic [N-1:0] y);
    if (x >= y) return x - y;
    return N'({1'b0, x} + {1'b0, QN} - {1'b0, y});
  endfunction

  function automatic logic [2*N-1:0] mul_full(input logic [N-1:0] x, input logic [N-1:0] y);
    return {{N{1'b0}}, x} * {{N{1'b0}}, y};
  endfunction

  function automatic logic [N-1:0] red_mod(input logic [2*N-1:0] p);
    return N'(p % Q2);
  endfunction

  logic en;
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  logic            vld_p1, vld_p2, vld_p3, vld_p4;
  logic [TAGW-1:0] tag_p1, tag_p2, tag_p3, tag_p4;
  logic            inv_p1;
  logic [N-1:0]    a_p1 [4];
  logic [N-1:0]    tf_p1 [4];
  logic [N-1:0]    tf_p2 [4];
  logic [N-1:0]    s02_p2, d02_p2, s13_p2, m_p2;
  logic [2*N-1:0]  prod_p3 [4];
  logic [N-1:0]    res_p4 [4];

  logic [N-1:0]    s02_c, d02_c, s13_c, d13_c, m_c, w_c;
  logic [N-1:0]    x_c [4];
  logic [2*N-1:0]  prod_c [4];

  always_comb begin
    w_c   = inv_p1 ? WI : WF;
    s02_c = add_mod(a_p1[0], a_p1[2]);
    d02_c = sub_mod(a_p1[0], a_p1[2]);
    s13_c = add_mod(a_p1[1], a_p1[3]);
    d13_c = sub_mod(a_p1[1], a_p1[3]);
    m_c   = red_mod(mul_full(w_c, d13_c));
  end

  always_comb begin
    x_c[0] = add_mod(s02_p2, s13_p2);
    x_c[1] = add_mod(d02_p2, m_p2);
    x_c[2] = sub_mod(s02_p2, s13_p2);
    x_c[3] = sub_mod(d02_p2, m_p2);
    for (int k = 0; k < 4; k++) prod_c[k] = mul_full(x_c[k], tf_p2[k]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
    end else if (en) begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      // S1: input registers
      tag_p1   <= in_tag;
      inv_p1   <= in_inv;
      a_p1[0]  <= a0;
      a_p1[1]  <= a1;
      a_p1[2]  <= a2;
      a_p1[3]  <= a3;
      tf_p1[0] <= tf0;
      tf_p1[1] <= tf1;
      tf_p1[2] <= tf2;
      tf_p1[3] <= tf3;
      // S2: partial sums/differences and reduced twiddle product
      tag_p2   <= tag_p1;
      tf_p2    <= tf_p1;
      s02_p2   <= s02_c;
      d02_p2   <= d02_c;
      s13_p2   <= s13_c;
      m_p2     <= m_c;
      // S3: butterfly outputs times output twiddles, unreduced
      tag_p3   <= tag_p2;
      prod_p3  <= prod_c;
    end
  end

  // S4: final reduction into the output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_p4 <= '0;
      for (int k = 0; k < 4; k++) res_p4[k] <= '0;
    end else if (en && vld_p3) begin
      tag_p4 <= tag_p3;
      for (int k = 0; k < 4; k++) res_p4[k] <= red_mod(prod_p3[k]);
    end
  end

  assign out_valid = vld_p4;
  assign out_tag   = tag_p4;
  assign A0        = res_p4[0];
  assign A1        = res_p4[1];
  assign A2        = res_p4[2];
  assign A3        = res_p4[3];

endmodule
